// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes,
// FSM states, lane widths and the alignment check.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RDATA = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  // An illegal size is reported through the same path as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane extraction (with optional sign extension) and lane merge for
// sub-word accesses; shared by the load path and the read-modify-write path.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] rdata_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [1:0]        lane_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [WORD_W-1:0] ext_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  assign byte_s = rdata_i[{lane_i, 3'b000} +: BYTE_W];
  assign half_s = rdata_i[{lane_i[1], 4'b0000} +: HALF_W];

  always_comb begin
    ext_o    = {WORD_W{1'b0}};
    merged_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        ext_o = {{(WORD_W-BYTE_W){signed_i & byte_s[BYTE_W-1]}}, byte_s};
        merged_o[{lane_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
      end
      SZ_HALF: begin
        ext_o = {{(WORD_W-HALF_W){signed_i & half_s[HALF_W-1]}}, half_s};
        merged_o[{lane_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
      end
      SZ_WORD: begin
        ext_o    = rdata_i;
        merged_o = wdata_i;
      end
      default: begin
        ext_o    = {WORD_W{1'b0}};
        merged_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator: one request at a time, sub-word stores
// done as read-modify-write, illegal accesses answered with an error pulse.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [29:0] widx_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept_s;
  logic        err_s;
  logic [31:0] ext_s;
  logic [31:0] merged_s;

  assign req_ready = (state_q == ST_IDLE);
  assign accept_s  = req_valid & req_ready;
  assign err_s     = is_misaligned(req_size, req_addr[1:0]) |
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  mem_lane_align u_align (
    .rdata_i  (mem_rdata),
    .wdata_i  (wdata_q),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .ext_o    (ext_s),
    .merged_o (merged_s)
  );

  // Control FSM with the registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      widx_q       <= 30'd0;
      wdata_q      <= 32'd0;
      merged_q     <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s && err_s) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (accept_s) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            widx_q   <= req_addr[31:2];
            wdata_q  <= req_wdata;
            state_q  <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (we_q && (size_q == SZ_WORD)) begin
            resp_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (we_q) begin
            merged_q <= merged_s;
            state_q  <= ST_WRITE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ext_s;
            state_q      <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port is decoded straight from state so reset drops mem_we at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_q)
      ST_ISSUE: begin
        mem_addr = {2'b00, widx_q};
        if (we_q && (size_q == SZ_WORD)) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end else begin
          mem_we    = 1'b0;
          mem_wdata = 32'd0;
        end
      end
      ST_RDATA: mem_addr = {2'b00, widx_q};
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = {2'b00, widx_q};
        mem_wdata = merged_q;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32-word data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] tb_mem [0:31];
  int          we_cnt = 0;
  logic [31:0] last_we_addr = 32'd0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: registered read, write when mem_we.
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[4:0]] <= mem_wdata;
      we_cnt                <= we_cnt + 1;
      last_we_addr          <= mem_addr;
    end
    mem_rdata <= tb_mem[mem_addr[4:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for its response; lat = edges from accept.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", 32'd0, 32'd1);
      lat = 99;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          we_base;

  logic        b_we [4];
  logic [1:0]  b_sz [4];
  logic        b_sg [4];
  logic [31:0] b_a  [4];
  logic [31:0] b_wd [4];
  logic [31:0] b_rd [4];
  logic        b_er [4];
  int          low_cnt;
  int          got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 32'd0;
    mem_rdata = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word store then load
    we_base = we_cnt;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", {31'd0, er}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_we_cnt", 32'(we_cnt - we_base), 32'd1);
    chk("sw_we_addr", last_we_addr, 32'd4);
    chk("sw_mem4", tb_mem[4], 32'hDEADBEEF);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'd0, er}, 32'd0);
    chk("lw_lat", 32'(lat), 32'd3);

    // Byte RMW and byte loads
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, er, lat);
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, rd, er, lat);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_mem4", tb_mem[4], 32'h80223344);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, rd, er, lat);
    chk("lbu", rd, 32'h00000080);
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, rd, er, lat);
    chk("lb_lane1", rd, 32'h00000033);

    // Halfword RMW and loads
    xact(1'b1, 2'b01, 1'b0, 32'h06, 32'h0000ABCD, rd, er, lat);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_mem1", tb_mem[1], 32'hABCD0000);
    xact(1'b0, 2'b01, 1'b1, 32'h06, 32'd0, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFFABCD);
    xact(1'b0, 2'b01, 1'b1, 32'h04, 32'd0, rd, er, lat);
    chk("lh_low", rd, 32'h00000000);

    // Last legal word
    xact(1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D, rd, er, lat);
    chk("top_store_err", {31'd0, er}, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h7C, 32'd0, rd, er, lat);
    chk("top_load", rd, 32'hCAFEF00D);

    // Error cases: one cycle, no memory write
    we_base = we_cnt;
    xact(1'b0, 2'b10, 1'b0, 32'h02, 32'd0, rd, er, lat);
    chk("err_lw_mis", {31'd0, er}, 32'd1);
    chk("err_lw_lat", 32'(lat), 32'd1);
    chk("err_lw_rdata", rd, 32'd0);
    xact(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, rd, er, lat);
    chk("err_sh_mis", {31'd0, er}, 32'd1);
    chk("err_sh_lat", 32'(lat), 32'd1);
    xact(1'b1, 2'b11, 1'b0, 32'h00, 32'h1234, rd, er, lat);
    chk("err_size", {31'd0, er}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, rd, er, lat);
    chk("err_range", {31'd0, er}, 32'd1);
    chk("err_range_lat", 32'(lat), 32'd1);
    chk("err_no_write", 32'(we_cnt - we_base), 32'd0);

    // Continuous req_valid burst
    b_we[0] = 1'b1; b_sz[0] = 2'b10; b_sg[0] = 1'b0; b_a[0] = 32'h20; b_wd[0] = 32'h0102F304; b_rd[0] = 32'd0;         b_er[0] = 1'b0;
    b_we[1] = 1'b0; b_sz[1] = 2'b10; b_sg[1] = 1'b0; b_a[1] = 32'h20; b_wd[1] = 32'd0;        b_rd[1] = 32'h0102F304; b_er[1] = 1'b0;
    b_we[2] = 1'b0; b_sz[2] = 2'b00; b_sg[2] = 1'b1; b_a[2] = 32'h21; b_wd[2] = 32'd0;        b_rd[2] = 32'hFFFFFFF3; b_er[2] = 1'b0;
    b_we[3] = 1'b0; b_sz[3] = 2'b10; b_sg[3] = 1'b0; b_a[3] = 32'h03; b_wd[3] = 32'd0;        b_rd[3] = 32'd0;         b_er[3] = 1'b1;
    low_cnt = 0;
    got = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int g;
          g = 0;
          req_we = b_we[i]; req_size = b_sz[i]; req_signed = b_sg[i];
          req_addr = b_a[i]; req_wdata = b_wd[i]; req_valid = 1'b1;
          while (!req_ready && g < 20) begin
            low_cnt++; g++;
            @(negedge clk);
          end
          @(negedge clk);
        end
        req_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (got < 4 && cyc < 60) begin
          @(posedge clk); #1;
          cyc++;
          if (resp_valid) begin
            if (got < 4) begin
              chk("burst_rdata", resp_rdata, b_rd[got]);
              chk("burst_err", {31'd0, resp_err}, {31'd0, b_er[got]});
            end
            got++;
          end
        end
      end
    join
    chk("burst_resp_cnt", 32'(got), 32'd4);
    chk("burst_ready_low", 32'(low_cnt), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("burst_no_extra", {31'd0, resp_valid}, 32'd0);
    end

    // Reset during the WRITE cycle of a byte store
    xact(1'b1, 2'b10, 1'b0, 32'h14, 32'h55667788, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h14; req_wdata = 32'h000000AA;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmw_in_write", {31'd0, mem_we}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("rst_word_kept", tb_mem[5], 32'h55667788);
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, rd, er, lat);
    chk("rst_reload", rd, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
